// File: rtl/ex_muldiv_unit_pkg.sv
// M-extension constants shared by the iterative multiply/divide unit and its bench.
package riscv_m_pkg;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    localparam logic [6:0] M_FUNCT7 = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mstate_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and the multiply/divide unit.
interface ex_muldiv_unit_if #(parameter int XLEN = 64);
    logic            start;
    logic            word;
    logic [2:0]      func3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            stall_req;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, word, func3, rs1_data, rs2_data, flush,
        input  stall_req, busy, done, result
    );

    modport slave (
        input  start, word, func3, rs1_data, rs2_data, flush,
        output stall_req, busy, done, result
    );
endinterface

// File: rtl/ex_muldiv_unit_iter_core.sv
// One radix-2 step per cycle on unsigned magnitudes: shift-add multiply or restoring divide.
// Outputs are the post-step register values so the caller can capture the final result on the last step.
module muldiv_iter_core #(parameter int XLEN = 64) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_in,
    input  logic [XLEN-1:0]   b_in,
    output logic [2*XLEN-1:0] prod_nxt,
    output logic [XLEN-1:0]   quot_nxt,
    output logic [XLEN-1:0]   rem_nxt
);
    // acc: product accumulator / partial remainder; sh: multiplicand / divisor; q: multiplier / quotient
    logic [2*XLEN-1:0] acc, sh, acc_d, sh_d;
    logic [XLEN-1:0]   q, q_d;
    logic [XLEN:0]     tmp, sub;
    logic              ge;

    always_comb begin
        tmp   = {acc[XLEN-1:0], q[XLEN-1]};
        ge    = (tmp >= {1'b0, sh[XLEN-1:0]});
        sub   = tmp - {1'b0, sh[XLEN-1:0]};
        acc_d = acc;
        sh_d  = sh;
        q_d   = q;
        if (is_div) begin
            acc_d = {{(XLEN-1){1'b0}}, ge ? sub : tmp};
            q_d   = {q[XLEN-2:0], ge};
        end else begin
            if (q[0]) acc_d = acc + sh;
            sh_d = {sh[2*XLEN-2:0], 1'b0};
            q_d  = {1'b0, q[XLEN-1:1]};
        end
    end

    assign prod_nxt = acc_d;
    assign quot_nxt = q_d;
    assign rem_nxt  = acc_d[XLEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            sh  <= '0;
            q   <= '0;
        end else if (load) begin
            acc <= '0;
            sh  <= {{XLEN{1'b0}}, b_in};
            q   <= a_in;
        end else if (step) begin
            acc <= acc_d;
            sh  <= sh_d;
            q   <= q_d;
        end
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M unit: N+1 cycles for normal ops (N = XLEN or XLEN/2), 1 cycle for divide special cases.
// Holds the pipeline via stall_req from acceptance through the last CALC step; flush aborts silently.
module ex_muldiv_unit import riscv_m_pkg::*; #(parameter int XLEN = 64) (
    input  logic        clk,
    input  logic        reset,
    ex_muldiv_unit_if.slave mdu
);
    localparam int HW = XLEN / 2;
    localparam int CW = $clog2(XLEN) + 1;

    mstate_t         state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_f3;
    logic            op_word, sa_q, sb_q;
    logic [XLEN-1:0] result_q;

    logic            is_div_in, a_signed, b_signed, sa, sb;
    logic            div_zero, div_ovf, special, accept;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_load, min_neg, spec_raw, spec_res;

    logic [2*XLEN-1:0] prod_nxt, prod_s;
    logic [XLEN-1:0]   quot_nxt, rem_nxt, quot_s, rem_s, raw, calc_res;
    logic              stall_now, busy_now, done_now;

    // Operand decode and divide special-case detection on the incoming instruction
    always_comb begin
        is_div_in = mdu.func3[2];
        if (is_div_in) begin
            a_signed = ~mdu.func3[0];
            b_signed = ~mdu.func3[0];
        end else if (mdu.word) begin
            a_signed = 1'b1;
            b_signed = 1'b1;
        end else begin
            a_signed = (mdu.func3 != M_MULHU);
            b_signed = (mdu.func3 == M_MUL) || (mdu.func3 == M_MULH);
        end
        a_ext = mdu.word ? {{HW{a_signed & mdu.rs1_data[HW-1]}}, mdu.rs1_data[HW-1:0]} : mdu.rs1_data;
        b_ext = mdu.word ? {{HW{b_signed & mdu.rs2_data[HW-1]}}, mdu.rs2_data[HW-1:0]} : mdu.rs2_data;
        sa    = a_signed & a_ext[XLEN-1];
        sb    = b_signed & b_ext[XLEN-1];
        a_mag = sa ? -a_ext : a_ext;
        b_mag = sb ? -b_ext : b_ext;
        min_neg  = mdu.word ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div_in && (b_ext == '0);
        div_ovf  = is_div_in && !mdu.func3[0] && (a_ext == min_neg) && (b_ext == '1);
        special  = div_zero || div_ovf;
        if (div_zero) spec_raw = mdu.func3[1] ? a_ext : '1;
        else          spec_raw = mdu.func3[1] ? '0 : a_ext;
        spec_res = mdu.word ? {{HW{spec_raw[HW-1]}}, spec_raw[HW-1:0]} : spec_raw;
        // word divides walk the dividend MSB-first, so left-align it
        a_load = (mdu.word && is_div_in) ? (a_mag << HW) : a_mag;
    end

    assign accept = (state == ST_IDLE) && mdu.start && !mdu.flush;

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rst      (reset),
        .load     (accept && !special),
        .step     (state == ST_CALC),
        .is_div   (op_f3[2]),
        .a_in     (a_load),
        .b_in     (b_mag),
        .prod_nxt (prod_nxt),
        .quot_nxt (quot_nxt),
        .rem_nxt  (rem_nxt)
    );

    always_comb begin
        prod_s = (sa_q ^ sb_q) ? -prod_nxt : prod_nxt;
        quot_s = (sa_q ^ sb_q) ? -quot_nxt : quot_nxt;
        rem_s  = sa_q ? -rem_nxt : rem_nxt;
        if (!op_f3[2]) raw = (op_word || op_f3 == M_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        else           raw = op_f3[1] ? rem_s : quot_s;
        calc_res = op_word ? {{HW{raw[HW-1]}}, raw[HW-1:0]} : raw;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept) state_nxt = special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (mdu.flush)            state_nxt = ST_IDLE;
                else if (cnt == CW'(1))   state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_now  = (state != ST_IDLE);
        done_now  = (state == ST_DONE) && !mdu.flush;
        stall_now = accept || (state == ST_CALC);
    end

    assign mdu.stall_req = stall_now;
    assign mdu.busy      = busy_now;
    assign mdu.done      = done_now;
    assign mdu.result    = result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            op_f3    <= '0;
            op_word  <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_f3   <= mdu.func3;
            op_word <= mdu.word;
            sa_q    <= sa;
            sb_q    <= sb;
            if (special) result_q <= spec_res;
            else         cnt <= mdu.word ? CW'(HW) : CW'(XLEN);
        end else if (state == ST_CALC) begin
            if (mdu.flush) begin
                cnt <= '0;
            end else begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) result_q <= calc_res;
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed vectors with hand-computed results and done-cycle latency.
module tb_ex_muldiv_unit;
    import riscv_m_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ex_muldiv_unit_if #(.XLEN(64)) mdu ();

    ex_muldiv_unit #(.XLEN(64)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu.slave)
    );

    typedef struct {
        logic [63:0] res;
        int          cyc;
        int          id;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] last_exp = '0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial begin
        forever begin
            @(negedge clk);
            if (mdu.done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 result %h, expected no done", mdu.result);
                end else begin
                    mon_e = sb_q.pop_front();
                    check64($sformatf("result_%0d", mon_e.id), mdu.result, mon_e.res);
                    check64($sformatf("done_cycle_%0d", mon_e.id), 64'(cyc), 64'(mon_e.cyc));
                end
            end
        end
    end

    task automatic wait_idle(input int id);
        int n = 0;
        while (mdu.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL timeout_%0d: busy=%b after %0d cycles, expected idle", id, mdu.busy, n);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int lat, input int id, input bit hold);
        exp_t e;
        bit   stall_bad;
        @(negedge clk);
        mdu.start = 1'b1; mdu.func3 = f3; mdu.word = w; mdu.rs1_data = a; mdu.rs2_data = b;
        e.res = exp; e.cyc = cyc + lat; e.id = id;
        sb_q.push_back(e);
        last_exp = exp;
        if (hold) begin
            // start stays high and operands wander while the pipeline is frozen
            stall_bad = 1'b0;
            for (int k = 0; k < lat; k++) begin
                #1;
                if (mdu.stall_req !== 1'b1) stall_bad = 1'b1;
                @(negedge clk);
                mdu.rs1_data = {$urandom, $urandom};
                mdu.rs2_data = {$urandom, $urandom};
            end
            mdu.start = 1'b0;
            #1;
            check64($sformatf("stall_held_%0d", id), {63'b0, stall_bad}, 64'd0);
            check64($sformatf("stall_in_done_%0d", id), {63'b0, mdu.stall_req}, 64'd0);
        end else begin
            @(negedge clk);
            mdu.start = 1'b0;
        end
        wait_idle(id);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mdu.start = 1'b0; mdu.word = 1'b0; mdu.func3 = 3'b0;
        mdu.rs1_data = '0; mdu.rs2_data = '0; mdu.flush = 1'b0;
        repeat (2) @(negedge clk);
        check64("reset_result", mdu.result, 64'd0);
        check64("reset_flags", {61'b0, mdu.stall_req, mdu.busy, mdu.done}, 64'd0);
        reset = 1'b0;

        issue(M_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1, 1'b1);
        issue(M_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65, 2, 1'b0);
        issue(M_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, 3, 1'b0);
        issue(M_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 4, 1'b0);
        issue(M_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 5, 1'b0);
        issue(M_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 6, 1'b0);
        issue(M_DIVU,   1'b0, 64'd100, 64'd7, 64'd14, 65, 7, 1'b0);
        issue(M_DIV,    1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 8, 1'b0);
        issue(M_REM,    1'b0, 64'd5, 64'd0, 64'd5, 1, 9, 1'b0);
        issue(M_DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 10, 1'b0);
        issue(M_REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 11, 1'b0);
        issue(M_DIV,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 12, 1'b0);
        issue(M_MUL,    1'b1, 64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, 64'd0, 33, 13, 1'b0);
        issue(M_MULH,   1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 14, 1'b0);
        issue(M_DIV,    1'b1, 64'hDEAD_BEEF_0000_0014, 64'h0000_0000_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 33, 15, 1'b0);
        issue(M_REM,    1'b1, 64'h0000_0000_FFFF_FFF9, 64'd4, 64'hFFFF_FFFF_FFFF_FFFD, 33, 16, 1'b0);
        issue(M_DIVU,   1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33, 17, 1'b0);
        issue(M_REMU,   1'b1, 64'h0000_0000_8000_0005, 64'h0000_0000_9000_0000, 64'hFFFF_FFFF_8000_0005, 33, 18, 1'b0);

        // flush in the same cycle as start wins
        @(negedge clk);
        mdu.start = 1'b1; mdu.flush = 1'b1; mdu.func3 = M_DIVU; mdu.word = 1'b0;
        mdu.rs1_data = 64'd9; mdu.rs2_data = 64'd3;
        #1;
        check64("flush_start_stall", {63'b0, mdu.stall_req}, 64'd0);
        @(negedge clk);
        mdu.start = 1'b0; mdu.flush = 1'b0;
        #1;
        check64("flush_start_busy", {63'b0, mdu.busy}, 64'd0);

        // flush in CALC cycle 10 aborts without a done pulse
        @(negedge clk);
        mdu.start = 1'b1; mdu.func3 = M_DIVU; mdu.rs1_data = 64'd1000; mdu.rs2_data = 64'd3;
        @(negedge clk);
        mdu.start = 1'b0;
        repeat (9) @(negedge clk);
        mdu.flush = 1'b1;
        @(negedge clk);
        mdu.flush = 1'b0;
        #1;
        check64("flush_busy", {63'b0, mdu.busy}, 64'd0);
        check64("flush_stall", {63'b0, mdu.stall_req}, 64'd0);
        check64("flush_result", mdu.result, last_exp);
        repeat (70) @(negedge clk);

        // async reset mid-CALC clears everything at once
        @(negedge clk);
        mdu.start = 1'b1; mdu.func3 = M_MUL; mdu.rs1_data = 64'd12345; mdu.rs2_data = 64'd678;
        @(negedge clk);
        mdu.start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        check64("midreset_result", mdu.result, 64'd0);
        check64("midreset_stall", {63'b0, mdu.stall_req}, 64'd0);
        check64("midreset_busy", {63'b0, mdu.busy}, 64'd0);
        check64("midreset_done", {63'b0, mdu.done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (70) @(negedge clk);

        issue(M_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65, 19, 1'b0);
        repeat (3) @(negedge clk);
        check64("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
